// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the RV32 run controller.
package cpu_run_ctrl_pkg;

  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    RUN     = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4
  } run_state_t;

  localparam int TOHOST_PASS_VAL = 1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: sequences the core reset, snoops the tohost store and
// reports pass/fail/timeout together with cycle and retire counts.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    RESET_CYCLES   = 3,
  parameter int                    TIMEOUT_CYCLES = 100,
  parameter int                    CNT_WIDTH      = 32,
  parameter logic [DATA_WIDTH-1:0] TOHOST_ADDR    = 'h0000_1000
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_restart,
  input  logic                  i_dmem_we,
  input  logic [DATA_WIDTH-1:0] i_dmem_addr,
  input  logic [DATA_WIDTH-1:0] i_dmem_wdata,
  input  logic                  i_instr_retire,
  output logic                  o_cpu_reset_n,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_fail,
  output logic                  o_timeout,
  output logic [DATA_WIDTH-1:0] o_exit_code,
  output logic [CNT_WIDTH-1:0]  o_cycle_cnt,
  output logic [CNT_WIDTH-1:0]  o_retire_cnt
);

  localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
  // Budget counter is independent of CNT_WIDTH so a narrow, saturating
  // cycle counter cannot hide the timeout.
  localparam int BUD_W  = $clog2(TIMEOUT_CYCLES + 1);

  run_state_t            state_q, state_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [BUD_W-1:0]      budget_q, budget_d;
  logic [DATA_WIDTH-1:0] exit_q, exit_d;
  logic                  cpu_rst_n_q, done_q, pass_q, fail_q, timeout_q;
  logic                  in_run, hit, clr;

  assign in_run = (state_q == RUN);
  assign hit    = in_run && i_dmem_we && (i_dmem_addr == TOHOST_ADDR) &&
                  (i_dmem_wdata != '0);

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    budget_d = budget_q;
    exit_d   = exit_q;
    clr      = 1'b0;
    unique case (state_q)
      HOLD: begin
        if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      RUN: begin
        budget_d = budget_q + BUD_W'(1);
        if (hit) begin
          exit_d  = i_dmem_wdata >> 1;
          state_d = (i_dmem_wdata == DATA_WIDTH'(TOHOST_PASS_VAL)) ? PASS : FAIL;
        end else if (budget_q == BUD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = TIMEOUT;
        end
      end
      default: begin
        if (i_restart) begin
          state_d  = HOLD;
          hold_d   = '0;
          budget_d = '0;
          exit_d   = '0;
          clr      = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= HOLD;
      hold_q      <= '0;
      budget_q    <= '0;
      exit_q      <= '0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      budget_q    <= budget_d;
      exit_q      <= exit_d;
      cpu_rst_n_q <= (state_d == RUN);
      done_q      <= (state_d == PASS) || (state_d == FAIL) || (state_d == TIMEOUT);
      pass_q      <= (state_d == PASS);
      fail_q      <= (state_d == FAIL);
      timeout_q   <= (state_d == TIMEOUT);
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (clr),
    .i_en      (in_run),
    .o_cnt     (o_cycle_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_retire_cnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (clr),
    .i_en      (in_run && i_instr_retire),
    .o_cnt     (o_retire_cnt)
  );

  assign o_cpu_reset_n = cpu_rst_n_q;
  assign o_done        = done_q;
  assign o_pass        = pass_q;
  assign o_fail        = fail_q;
  assign o_timeout     = timeout_q;
  assign o_exit_code   = exit_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: randomized runs against a counting model.
module tb_cpu_run_ctrl;

  localparam int          TMO    = 100;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n, restart, we, retire;
  logic [31:0] addr, wdata;
  logic        cpu_rst_n, done, pass, fail, tmo;
  logic [31:0] exit_code, cyc, ret;

  logic        rst2_n, restart2, we2, retire2;
  logic [31:0] addr2, wdata2;
  logic        c2_cpu_rst_n, c2_done, c2_pass, c2_fail, c2_tmo;
  logic [31:0] c2_exit;
  logic [3:0]  c2_cyc, c2_ret;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_restart(restart), .i_dmem_we(we),
    .i_dmem_addr(addr), .i_dmem_wdata(wdata), .i_instr_retire(retire),
    .o_cpu_reset_n(cpu_rst_n), .o_done(done), .o_pass(pass), .o_fail(fail),
    .o_timeout(tmo), .o_exit_code(exit_code), .o_cycle_cnt(cyc), .o_retire_cnt(ret)
  );

  cpu_run_ctrl #(.CNT_WIDTH(4), .TIMEOUT_CYCLES(40)) dut2 (
    .i_clk(clk), .i_reset_n(rst2_n), .i_restart(restart2), .i_dmem_we(we2),
    .i_dmem_addr(addr2), .i_dmem_wdata(wdata2), .i_instr_retire(retire2),
    .o_cpu_reset_n(c2_cpu_rst_n), .o_done(c2_done), .o_pass(c2_pass), .o_fail(c2_fail),
    .o_timeout(c2_tmo), .o_exit_code(c2_exit), .o_cycle_cnt(c2_cyc), .o_retire_cnt(c2_ret)
  );

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    restart = 1'b0; we = 1'b0; retire = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic enter_run();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic restart_to_run();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    repeat (3) tick();
  endtask

  // Drive a store that must not end the run.
  task automatic drive_decoy(input int c, input int stop);
    int r;
    we = 1'b0; addr = '0; wdata = '0;
    if (c == stop - 2) begin
      we = 1'b1; addr = TOHOST; wdata = 32'd0;
    end else if (c == stop - 1) begin
      we = 1'b1; addr = TOHOST + 32'd4; wdata = 32'd1;
    end else begin
      r = $urandom_range(0, 4);
      case (r)
        1: begin we = 1'b1; addr = TOHOST; wdata = 32'd0; end
        2: begin we = 1'b1; addr = TOHOST + 32'd4; wdata = $urandom | 32'd1; end
        3: begin
          we = 1'b1; addr = $urandom; wdata = $urandom;
          if (addr == TOHOST) addr = addr ^ 32'd4;
        end
        4: begin we = 1'b0; addr = TOHOST; wdata = 32'd1; end
        default: ;
      endcase
    end
  endtask

  // From the first RUN cycle: decoys, then a tohost store of wd at RUN cycle stop.
  // nret >= 0 retires on the first nret cycles, otherwise retire is random.
  task automatic run_case(input int stop, input logic [31:0] wd, input int nret);
    int exp_ret;
    exp_ret = 0;
    for (int c = 0; c <= stop; c++) begin
      checks++;
      if (cyc !== 32'(c) || done !== 1'b0 || cpu_rst_n !== 1'b1) begin
        errors++;
        $display("FAIL run_progress c=%0d act cyc=%0d done=%b cpu=%b exp cyc=%0d done=0 cpu=1",
                 c, cyc, done, cpu_rst_n, c);
      end
      retire = (nret >= 0) ? (c < nret) : ($urandom_range(0, 1) == 1);
      if (retire) exp_ret++;
      if (c == stop) begin
        we = 1'b1; addr = TOHOST; wdata = wd;
      end else begin
        drive_decoy(c, stop);
      end
      tick();
    end
    idle_inputs();
    checks++;
    if ({done, pass, fail, tmo} !== {1'b1, wd == 32'd1, wd != 32'd1, 1'b0}) begin
      errors++;
      $display("FAIL end_flags act=%b%b%b%b exp=1%b%b0", done, pass, fail, tmo,
               wd == 32'd1, wd != 32'd1);
    end
    checks++;
    if (exit_code !== (wd >> 1)) begin
      errors++;
      $display("FAIL exit_code act=%0h exp=%0h", exit_code, wd >> 1);
    end
    checks++;
    if (cyc !== 32'(stop + 1)) begin
      errors++;
      $display("FAIL end_cycle act=%0d exp=%0d", cyc, stop + 1);
    end
    checks++;
    if (ret !== 32'(exp_ret)) begin
      errors++;
      $display("FAIL end_retire act=%0d exp=%0d", ret, exp_ret);
    end
    checks++;
    if (cpu_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL end_cpu_reset act=%b exp=0", cpu_rst_n);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({cpu_rst_n, done, pass, fail, tmo} !== 5'b0 || cyc !== 0 || ret !== 0 || exit_code !== 0) begin
      errors++;
      $display("FAIL reset_values act cpu=%b flags=%b%b%b%b cyc=%0d ret=%0d exit=%0h exp all 0",
               cpu_rst_n, done, pass, fail, tmo, cyc, ret, exit_code);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (cpu_rst_n !== (i == 3)) begin
        errors++;
        $display("FAIL reset_release edge=%0d act=%b exp=%b", i, cpu_rst_n, i == 3);
      end
    end
    checks++;
    if (cyc !== 32'd0) begin
      errors++;
      $display("FAIL first_run_cycle act=%0d exp=0", cyc);
    end
    tick();
    checks++;
    if (cyc !== 32'd1) begin
      errors++;
      $display("FAIL second_run_cycle act=%0d exp=1", cyc);
    end
  endtask

  task automatic test_frozen();
    logic [31:0] c0, r0, e0;
    logic [3:0]  f0;
    c0 = cyc; r0 = ret; e0 = exit_code; f0 = {done, pass, fail, tmo};
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; addr = TOHOST; wdata = (i == 0) ? 32'd1 : 32'd9; retire = 1'b1;
      tick();
    end
    idle_inputs();
    checks++;
    if (cyc !== c0 || ret !== r0 || exit_code !== e0 || {done, pass, fail, tmo} !== f0 || cpu_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL frozen act cyc=%0d ret=%0d exit=%0h flags=%b cpu=%b exp %0d %0d %0h %b 0",
               cyc, ret, exit_code, {done, pass, fail, tmo}, cpu_rst_n, c0, r0, e0, f0);
    end
  endtask

  task automatic test_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if ({cpu_rst_n, done, pass, fail, tmo} !== 5'b0 || cyc !== 0 || ret !== 0 || exit_code !== 0) begin
      errors++;
      $display("FAIL restart_clear act cpu=%b flags=%b%b%b%b cyc=%0d ret=%0d exit=%0h exp all 0",
               cpu_rst_n, done, pass, fail, tmo, cyc, ret, exit_code);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (cpu_rst_n !== (i == 3)) begin
        errors++;
        $display("FAIL restart_hold edge=%0d act=%b exp=%b", i, cpu_rst_n, i == 3);
      end
    end
    checks++;
    if (cyc !== 32'd0) begin
      errors++;
      $display("FAIL restart_run_cycle act=%0d exp=0", cyc);
    end
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if (cpu_rst_n !== 1'b1 || cyc !== 32'd2 || done !== 1'b0) begin
      errors++;
      $display("FAIL restart_in_run act cpu=%b cyc=%0d done=%b exp 1 2 0", cpu_rst_n, cyc, done);
    end
  endtask

  task automatic test_timeout();
    int exp_ret;
    exp_ret = 0;
    enter_run();
    for (int c = 0; c < TMO; c++) begin
      checks++;
      if (done !== 1'b0 || cyc !== 32'(c)) begin
        errors++;
        $display("FAIL timeout_progress c=%0d act done=%b cyc=%0d exp 0 %0d", c, done, cyc, c);
      end
      retire = ($urandom_range(0, 1) == 1);
      if (retire) exp_ret++;
      drive_decoy(c, -10);
      tick();
    end
    idle_inputs();
    checks++;
    if ({done, pass, fail, tmo} !== 4'b1001 || cyc !== 32'(TMO) || ret !== 32'(exp_ret) ||
        exit_code !== 0 || cpu_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL timeout_end act flags=%b cyc=%0d ret=%0d exit=%0h cpu=%b exp 1001 %0d %0d 0 0",
               {done, pass, fail, tmo}, cyc, ret, exit_code, cpu_rst_n, TMO, exp_ret);
    end
  endtask

  task automatic test_random();
    logic [31:0] wd;
    int          stop;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 2))
        0: wd = 32'd1;
        1: begin wd = $urandom | 32'd1; if (wd == 32'd1) wd = 32'd3; end
        default: begin wd = $urandom & ~32'd1; if (wd == 32'd0) wd = 32'd2; end
      endcase
      stop = $urandom_range(0, TMO - 1);
      restart_to_run();
      run_case(stop, wd, -1);
    end
  endtask

  task automatic test_async_reset();
    enter_run();
    retire = 1'b1;
    repeat (5) tick();
    retire = 1'b0;
    checks++;
    if (cyc !== 32'd5 || ret !== 32'd5) begin
      errors++;
      $display("FAIL async_pre act cyc=%0d ret=%0d exp 5 5", cyc, ret);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_rst_n, done, pass, fail, tmo} !== 5'b0 || cyc !== 0 || ret !== 0 || exit_code !== 0) begin
      errors++;
      $display("FAIL async_reset act cpu=%b cyc=%0d ret=%0d exp 0 0 0", cpu_rst_n, cyc, ret);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_saturate();
    int exp_c;
    restart2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0; retire2 = 1'b0;
    rst2_n = 1'b1;
    repeat (3) tick();
    retire2 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      exp_c = (c > 15) ? 15 : c;
      checks++;
      if (c2_cyc !== 4'(exp_c) || c2_tmo !== 1'b0 || c2_cpu_rst_n !== 1'b1) begin
        errors++;
        $display("FAIL sat_progress c=%0d act cyc=%0d tmo=%b cpu=%b exp %0d 0 1",
                 c, c2_cyc, c2_tmo, c2_cpu_rst_n, exp_c);
      end
      tick();
    end
    retire2 = 1'b0;
    checks++;
    if ({c2_done, c2_pass, c2_fail, c2_tmo} !== 4'b1001 || c2_cyc !== 4'd15 || c2_ret !== 4'd15) begin
      errors++;
      $display("FAIL sat_timeout act flags=%b cyc=%0d ret=%0d exp 1001 15 15",
               {c2_done, c2_pass, c2_fail, c2_tmo}, c2_cyc, c2_ret);
    end
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    restart2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0; retire2 = 1'b0;
    idle_inputs();
    test_reset();
    enter_run();
    run_case(20, 32'd1, 15);
    test_frozen();
    test_restart();
    enter_run();
    run_case(5, 32'd7, -1);
    test_frozen();
    test_timeout();
    test_frozen();
    enter_run();
    run_case(TMO - 1, 32'd1, -1);
    test_random();
    test_async_reset();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
